// File: rtl/polyphase_interp.sv
// polyphase_interp
//   Time-multiplexed polyphase interpolator. Each accepted input sample
//   produces UPFACTOR output samples. Output phase p is
//   y_p = sum_k h[k*UPFACTOR+p] * x[k], computed with one
//   multiplier-accumulator. Each result is rounded to OW bits with
//   round-half-to-even, then either saturated or wrapped.
//
// Ports
//   i_clk, i_reset_n    clock; asynchronous active-low reset
//   i_coef_we/addr/data coefficient RAM write (ignored while o_busy)
//   i_valid, o_ready    input sample handshake, sample on i_sample
//   o_valid, i_ready    output sample handshake, sample on o_sample
//   o_busy              block is not idle
//   o_ovf               sticky overflow flag (cleared only by reset)
module polyphase_interp #(
  parameter int IW       = 16,
  parameter int TW       = 16,
  parameter int OW       = 16,
  parameter int NTAPS    = 32,
  parameter int UPFACTOR = 4,
  parameter int SAT      = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_coef_we,
  input  logic [$clog2(NTAPS)-1:0] i_coef_addr,
  input  logic [TW-1:0]            i_coef_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [IW-1:0]            i_sample,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [OW-1:0]            o_sample,
  output logic                     o_busy,
  output logic                     o_ovf
);

  localparam int L   = NTAPS / UPFACTOR;
  localparam int AW  = IW + TW + $clog2(L);
  localparam int D   = IW + TW - 1 - OW;
  localparam int PW  = $clog2(UPFACTOR);
  localparam int KW  = $clog2(L + 1);
  localparam int LW  = $clog2(L);
  localparam int MW  = IW + TW;
  localparam int CAW = $clog2(NTAPS);
  // One bit more than the truncated accumulator, so the round-up carry can
  // never wrap.
  localparam int RW  = AW - D + 1;

  localparam logic [KW-1:0] KLAST = KW'(L);
  localparam logic [PW-1:0] PLAST = PW'(UPFACTOR - 1);
  localparam logic [D-1:0]  HALF  = D'(1) << (D - 1);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  function automatic logic signed [RW-1:0] round_conv(input logic signed [AW-1:0] a);
    logic signed [RW-1:0] t;
    logic [D-1:0]         rem;
    logic                 up;
    t   = RW'(a >>> D);
    rem = a[D-1:0];
    up  = (rem > HALF) || ((rem == HALF) && t[0]);
    return t + signed'({{(RW-1){1'b0}}, up});
  endfunction

  function automatic logic fits_ow(input logic signed [RW-1:0] r);
    logic signed [OW-1:0] lo;
    lo = r[OW-1:0];
    return RW'(lo) == r;
  endfunction

  function automatic logic [OW-1:0] to_ow(input logic signed [RW-1:0] r);
    if (fits_ow(r) || (SAT == 0)) return r[OW-1:0];
    return r[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
  endfunction

  state_e               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic [KW-1:0]        k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [MW-1:0] prod_q, prod_d;
  logic                 valid_q, valid_d;
  logic [OW-1:0]        sample_q, sample_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;

  // The coefficient RAM has no reset, so its contents survive i_reset_n.
  logic signed [TW-1:0] coef_q [NTAPS];
  logic signed [IW-1:0] x_q [L];

  logic [LW-1:0]        k_idx;
  logic [CAW-1:0]       tap_idx;
  logic signed [MW-1:0] mult;
  logic signed [AW-1:0] acc_sum;
  logic signed [RW-1:0] rounded;

  assign o_ready  = (state_q == IDLE);
  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_sample = sample_q;
  assign o_ovf    = ovf_q;

  always_ff @(posedge i_clk) begin
    if (i_coef_we && !o_busy) coef_q[i_coef_addr] <= i_coef_data;
  end

  // Stage 0: tap select and multiply. k == L is the drain cycle and has no
  // tap, so the index is held at 0 to stay inside the arrays.
  always_comb begin
    k_idx   = (k_q < KLAST) ? LW'(k_q) : '0;
    tap_idx = CAW'(int'(k_idx) * UPFACTOR + int'(p_q));
    mult    = MW'(coef_q[tap_idx]) * MW'(x_q[k_idx]);
    acc_sum = acc_q + AW'(prod_q);
    rounded = round_conv(acc_sum);
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    k_d      = k_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          accept  = 1'b1;
          state_d = MAC;
          p_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          prod_d  = '0;
        end
      end
      MAC: begin
        // Stage 1: accumulate the product registered on the previous cycle.
        acc_d = acc_sum;
        if (k_q < KLAST) begin
          prod_d = mult;
          k_d    = k_q + KW'(1);
        end else begin
          prod_d   = '0;
          state_d  = OUT;
          valid_d  = 1'b1;
          sample_d = to_ow(rounded);
          if (!fits_ow(rounded)) ovf_d = 1'b1;
        end
      end
      OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (p_q != PLAST) begin
            p_d     = p_q + PW'(1);
            k_d     = '0;
            acc_d   = '0;
            prod_d  = '0;
            state_d = MAC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      p_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      valid_q  <= 1'b0;
      sample_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < L; i++) x_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      ovf_q    <= ovf_d;
      if (accept) begin
        for (int i = L - 1; i > 0; i--) x_q[i] <= x_q[i-1];
        x_q[0] <= i_sample;
      end
    end
  end

endmodule

// File: tb/tb_polyphase_interp.sv
// Directed bench for polyphase_interp with default parameters. A second
// instance with SAT=0 runs the same stimulus to cover wrap mode.
module tb_polyphase_interp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_data;
  logic        in_valid;
  logic        rdy;
  logic [15:0] in_sample;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic        busy;
  logic        ovf;
  logic        rdy_w, valid_w, busy_w, ovf_w;
  logic [15:0] sample_w;
  logic [15:0] last_w;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  polyphase_interp #(.SAT(1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_coef_we(coef_we), .i_coef_addr(coef_addr),
    .i_coef_data(coef_data), .i_valid(in_valid), .o_ready(rdy), .i_sample(in_sample),
    .o_valid(out_valid), .i_ready(out_ready), .o_sample(out_sample), .o_busy(busy),
    .o_ovf(ovf)
  );

  polyphase_interp #(.SAT(0)) dut_w (
    .i_clk(clk), .i_reset_n(rst_n), .i_coef_we(coef_we), .i_coef_addr(coef_addr),
    .i_coef_data(coef_data), .i_valid(in_valid), .o_ready(rdy_w), .i_sample(in_sample),
    .o_valid(valid_w), .i_ready(out_ready), .o_sample(sample_w), .o_busy(busy_w),
    .o_ovf(ovf_w)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int n = 0; n < 32; n++) wr(5'(n), 16'(n * 256));
  endtask

  task automatic load_const(input logic [15:0] v);
    for (int n = 0; n < 32; n++) wr(5'(n), v);
  endtask

  task automatic send(input logic [15:0] s);
    int t = 0;
    while (!rdy && t < 100) begin tick(); t++; end
    if (t >= 100) chk("send_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b1; in_sample = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [15:0] exp, input bit do_chk);
    int t = 0;
    while (!out_valid && t < 100) begin tick(); t++; end
    if (do_chk) chk(tag, 32'({out_valid, out_sample}), 32'({1'b1, exp}));
    last_w = sample_w;
    tick();
  endtask

  initial begin
    int a1, a2, v1, t;
    logic prev_v;
    rst_n = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    in_valid = 1'b0; in_sample = '0; out_ready = 1'b1; last_w = '0;
    tick(); tick();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sample", 32'(out_sample), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(rdy), 32'd1);

    // Impulse response through the ramp coefficients
    load_ramp();
    send(16'h4000);
    for (int p = 0; p < 4; p++) recv($sformatf("imp_j0_p%0d", p), 16'(p * 128), 1'b1);
    for (int j = 1; j <= 8; j++) begin
      send(16'h0000);
      for (int p = 0; p < 4; p++)
        recv($sformatf("imp_j%0d_p%0d", j, p), (j < 8) ? 16'((4 * j + p) * 128) : 16'h0000, 1'b1);
    end
    chk("imp_ovf", 32'(ovf), 32'd0);

    // Convergent rounding with only h[0] nonzero
    load_const(16'h0000);
    wr(5'd0, 16'h0001);
    send(16'h4000);
    recv("rnd_half_even", 16'h0000, 1'b1);
    for (int p = 1; p < 4; p++) recv("rnd_other", 16'h0000, 1'b1);
    wr(5'd0, 16'h0003);
    send(16'h4000);
    recv("rnd_1p5", 16'h0002, 1'b1);
    for (int p = 1; p < 4; p++) recv("rnd_other", 16'h0000, 1'b0);
    wr(5'd0, 16'h0001);
    send(16'h6000);
    recv("rnd_0p75", 16'h0001, 1'b1);
    for (int p = 1; p < 4; p++) recv("rnd_other", 16'h0000, 1'b0);
    send(16'hC000);
    recv("rnd_neg_half", 16'h0000, 1'b1);
    for (int p = 1; p < 4; p++) recv("rnd_other", 16'h0000, 1'b0);
    chk("rnd_ovf", 32'(ovf), 32'd0);

    // Overflow: positive full scale, saturate and wrap
    load_const(16'h7FFF);
    for (int j = 0; j < 7; j++) begin
      send(16'h7FFF);
      for (int p = 0; p < 4; p++) recv("ovf_fill", 16'h0000, 1'b0);
    end
    send(16'h7FFF);
    for (int p = 0; p < 4; p++) begin
      recv($sformatf("sat_pos_p%0d", p), 16'h7FFF, 1'b1);
      chk($sformatf("wrap_pos_p%0d", p), 32'(last_w), 32'h0000FFF0);
    end
    chk("sat_ovf", 32'(ovf), 32'd1);
    chk("wrap_ovf", 32'(ovf_w), 32'd1);

    // Overflow: negative full scale
    for (int j = 0; j < 7; j++) begin
      send(16'h8000);
      for (int p = 0; p < 4; p++) recv("ovf_fill", 16'h0000, 1'b0);
    end
    send(16'h8000);
    for (int p = 0; p < 4; p++) begin
      recv($sformatf("sat_neg_p%0d", p), 16'h8000, 1'b1);
      chk($sformatf("wrap_neg_p%0d", p), 32'(last_w), 32'h00000008);
    end

    // Reset in the middle of MAC
    load_ramp();
    send(16'h4000);
    tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_ovf", 32'(ovf), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sample", 32'(out_sample), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(rdy), 32'd1);

    // Delay line cleared, coefficients kept
    send(16'h4000);
    for (int p = 0; p < 4; p++) recv($sformatf("post_rst_p%0d", p), 16'(p * 128), 1'b1);

    // Coefficient write while busy must be ignored
    send(16'h0000);
    tick(); tick();
    wr(5'd0, 16'h7FFF);
    for (int p = 0; p < 4; p++) recv($sformatf("busy_wr_a_p%0d", p), 16'((4 + p) * 128), 1'b1);
    send(16'h4000);
    for (int p = 0; p < 4; p++) recv($sformatf("busy_wr_b_p%0d", p), 16'((8 + 2 * p) * 128), 1'b1);

    // Backpressure on phase 0 with a pending input
    send(16'h0000);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 100) begin tick(); t++; end
    in_valid = 1'b1; in_sample = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold_c%0d", c), 32'({rdy, out_valid, out_sample}), 32'({2'b01, 16'h0800}));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) recv($sformatf("bp_p%0d", p), 16'((16 + 2 * p) * 128), 1'b1);
    chk("bp_idle", 32'({busy, out_valid}), 32'd0);
    send(16'h0000);
    for (int p = 0; p < 4; p++) recv($sformatf("bp_next_p%0d", p), 16'((24 + 2 * p) * 128), 1'b1);

    // Throughput with both handshakes held high
    in_sample = 16'h0000;
    in_valid = 1'b1;
    a1 = -1; a2 = -1; v1 = -1; prev_v = out_valid;
    for (int c = 0; c < 150 && a2 < 0; c++) begin
      if (rdy) begin
        if (a1 < 0) a1 = cyc + 1;
        else a2 = cyc + 1;
      end
      if (out_valid && !prev_v && a1 >= 0 && v1 < 0) v1 = cyc;
      prev_v = out_valid;
      tick();
    end
    in_valid = 1'b0;
    t = 0;
    while (busy && t < 100) begin tick(); t++; end
    chk("tp_accept_gap", 32'(a2 - a1), 32'd41);
    chk("tp_first_valid", 32'(v1 - a1), 32'd9);
    chk("tp_drained", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
